// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int product_width(input int word_length);
    return 2 * word_length;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand shift registers, accumulator, adder and product register for the
// shift-and-add multiplier; sequencing comes from the controller above it.
module mult_datapath
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load,
  input  logic                                  step,
  input  logic                                  last,
  input  logic                                  signed_op,
  input  logic [WORD_LENGTH-1:0]                data_in_a,
  input  logic [WORD_LENGTH-1:0]                data_in_b,
  output logic [product_width(WORD_LENGTH)-1:0] product
);

  localparam int PW = product_width(WORD_LENGTH);

  logic [PW-1:0]          mcand_reg;
  logic [WORD_LENGTH-1:0] mplier_reg;
  logic [PW-1:0]          acc_reg;
  logic [PW-1:0]          result_reg;
  logic                   negate_reg;

  logic [WORD_LENGTH-1:0] mag_a;
  logic [WORD_LENGTH-1:0] mag_b;
  logic [PW-1:0]          acc_sum;

  // Signed operands are reduced to magnitudes; the most negative value maps
  // onto itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    mag_a = (signed_op && data_in_a[WORD_LENGTH-1]) ? -data_in_a : data_in_a;
    mag_b = (signed_op && data_in_b[WORD_LENGTH-1]) ? -data_in_b : data_in_b;
    acc_sum = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      negate_reg <= 1'b0;
    end else if (load) begin
      mcand_reg  <= {{WORD_LENGTH{1'b0}}, mag_a};
      mplier_reg <= mag_b;
      acc_reg    <= '0;
      result_reg <= '0;
      negate_reg <= signed_op && (data_in_a[WORD_LENGTH-1] ^ data_in_b[WORD_LENGTH-1]);
    end else if (step) begin
      mcand_reg  <= {mcand_reg[PW-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[WORD_LENGTH-1:1]};
      acc_reg    <= acc_sum;
      if (last) begin
        result_reg <= negate_reg ? -acc_sum : acc_sum;
      end
    end
  end

  assign product = result_reg;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: controller FSM and iteration counter.
// Define SIGNED_MODE_EN to add the signed_op port for two's-complement operands.
module shift_add_multiplier
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
`ifdef SIGNED_MODE_EN
  input  logic                                  signed_op,
`endif
  input  logic [WORD_LENGTH-1:0]                data_in_a,
  input  logic [WORD_LENGTH-1:0]                data_in_b,
  output logic                                  busy,
  output logic                                  done,
  output logic [product_width(WORD_LENGTH)-1:0] data_out
);

  localparam int CW = $clog2(WORD_LENGTH + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          load;
  logic          step;
  logic          last;
  logic          op_signed;

`ifdef SIGNED_MODE_EN
  assign op_signed = signed_op;
`else
  assign op_signed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          count_next = CW'(WORD_LENGTH);
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        // Fixed WORD_LENGTH iterations regardless of operand values.
        step       = 1'b1;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  mult_datapath #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .last      (last),
    .signed_op (op_signed),
    .data_in_a (data_in_a),
    .data_in_b (data_in_b),
    .product   (data_out)
  );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WORD_LENGTH=4.
// Signed vectors are exercised when built with SIGNED_MODE_EN.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       signed_op;
  logic [3:0] data_in_a;
  logic [3:0] data_in_b;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int done_count;

  shift_add_multiplier #(.WORD_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SIGNED_MODE_EN
    .signed_op (signed_op),
`endif
    .data_in_a (data_in_a),
    .data_in_b (data_in_b),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at edge N, check busy during N+1..N+4 and the product at N+5.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                        input logic [7:0] expected, input string tag);
    data_in_a = a;
    data_in_b = b;
    signed_op = sgn;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_run_done"}, 32'(done), 32'd0);
      check({tag, "_run_out"}, 32'(data_out), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(data_out), 32'(expected));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(data_out), 32'(expected));
    $display("op %s a=%0d b=%0d signed=%0d product=%0d", tag, a, b, sgn, data_out);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    signed_op = 1'b0;
    data_in_a = 4'd5;
    data_in_b = 4'd5;
    tick();
    tick();
    // Reset wins over a simultaneous start.
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    run_op(4'd15, 4'd15, 1'b0, 8'd225, "all_ones");
    run_op(4'd0,  4'd9,  1'b0, 8'd0,   "zero_a");
    run_op(4'd13, 4'd11, 1'b0, 8'd143, "13x11");
    run_op(4'd15, 4'd1,  1'b0, 8'd15,  "15x1");

    // Start held through RUN with changing operands, then back-to-back start in DONE.
    done_count = 0;
    data_in_a = 4'd3;
    data_in_b = 4'd5;
    start = 1'b1;
    tick();
    data_in_a = 4'd7;
    data_in_b = 4'd7;
    for (int k = 1; k <= 4; k++) begin
      check("held_busy", 32'(busy), 32'd1);
      if (done) done_count++;
      tick();
    end
    if (done) done_count++;
    check("held_single_done", 32'(done_count), 32'd1);
    check("held_product", 32'(data_out), 32'd15);
    $display("op held a=3 b=5 product=%0d", data_out);
    data_in_a = 4'd2;
    data_in_b = 4'd6;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_cleared", 32'(data_out), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_product", 32'(data_out), 32'd12);
    $display("op b2b a=2 b=6 product=%0d", data_out);
    tick();

    // Reset pulsed mid-RUN at edge N+2 aborts the operation silently.
    data_in_a = 4'd9;
    data_in_b = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", 32'(data_out), 32'd0);
    done_count = 0;
    for (int k = 3; k <= 8; k++) begin
      if (done) done_count++;
      tick();
    end
    check("abort_no_done", 32'(done_count), 32'd0);
    check("abort_out_after", 32'(data_out), 32'd0);
    $display("op abort a=9 b=9 dones=%0d", done_count);

`ifdef SIGNED_MODE_EN
    run_op(4'b1000, 4'b1000, 1'b1, 8'h40, "s_m8xm8");
    run_op(4'b1101, 4'd5,    1'b1, 8'hF1, "s_m3x5");
    run_op(4'd7,    4'b1111, 1'b1, 8'hF9, "s_7xm1");
    run_op(4'b1101, 4'd5,    1'b0, 8'd65, "u_13x5");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WORD_LENGTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiplication; sampled only when the block is idle.
REQ-005 Port: data_in_a  input  WORD_LENGTH  multiplicand; captured on the accepting edge.
REQ-006 Port: data_in_b  input  WORD_LENGTH  multiplier; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a valid product.
REQ-009 Port: data_out  output  2*WORD_LENGTH  product.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE; reset enters IDLE.
REQ-011 IDLE or DONE with start=1 at edge N SHALL latch both operands, clear the accumulator, load the iteration counter with WORD_LENGTH and enter RUN.
REQ-012 Each RUN cycle SHALL add the left-shifted multiplicand to the accumulator when the multiplier LSB is 1, then shift the multiplicand left 1, shift the multiplier right 1 and decrement the counter.
REQ-013 RUN SHALL last exactly WORD_LENGTH cycles (N+1..N+WORD_LENGTH), independent of operand values (no early termination).
REQ-014 busy SHALL be 1 exactly in cycles N+1..N+WORD_LENGTH.
REQ-015 In cycle N+WORD_LENGTH+1 the FSM SHALL be in DONE, done=1 and data_out SHALL equal the full 2*WORD_LENGTH-bit product.
REQ-016 DONE SHALL last one cycle; without start it returns to IDLE; with start it accepts the new operation (back-to-back, one-cycle gap).
REQ-017 data_out SHALL hold the last product until the next accepted start, then read 0 while busy.
REQ-018 start while busy=1 SHALL be ignored; operand changes during RUN SHALL not affect the result.
REQ-019 The accumulator SHALL be 2*WORD_LENGTH bits; no overflow is possible; the unsigned product of all-ones operands is exact.

Reset
REQ-020 reset=1 at any edge, including mid-RUN, SHALL force IDLE with busy=0, done=0, data_out=0, counter=0 and the operand registers=0; the aborted operation produces no done.
REQ-021 reset SHALL take priority over start on the same edge.

Configuration
REQ-022 Macro SIGNED_MODE_EN, when defined, SHALL add input port signed_op (1 bit, sampled with start), selecting two's-complement operands.
REQ-023 With signed_op=1, the block SHALL multiply operand magnitudes and negate the product when the operand signs differ; latency is unchanged.
REQ-024 Without SIGNED_MODE_EN, signed_op SHALL be absent and all operands are unsigned; behaviour is as in REQ-010..REQ-021.

Structure
REQ-025 Package multiplier_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the product-width constant function.
REQ-026 Sub-module mult_datapath SHALL contain the operand shift registers, accumulator and adder; shift_add_multiplier SHALL contain the FSM and counter.

Verification (WORD_LENGTH=4)
REQ-027 a=15, b=15, start at edge N -> busy during N+1..N+4; done=1 and data_out=225 (0xE1) at N+5.
REQ-028 a=0, b=9 -> data_out=0, done still at N+5.
REQ-029 a=3, b=5, start=1 held and operands changed to 7/7 during RUN -> data_out=15, single done; then start in DONE with a=2, b=6 -> data_out=12 at N+10.
REQ-030 a=9, b=9, reset pulsed at N+2 -> busy=0, data_out=0 at N+3, no done through N+8.
REQ-031 SIGNED_MODE_EN, signed_op=1: a=-8, b=-8 -> 64 (0x40); a=-3, b=5 -> -15 (0xF1).
